// File: rtl/packet_pkg.sv
// Shared packet definitions and legality rules for the 4-port switch.
package packet_pkg;

    localparam int unsigned NUM_PORTS  = 4;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned PKT_WIDTH  = 16;

    localparam int unsigned SRC_MSB  = 15;
    localparam int unsigned SRC_LSB  = 12;
    localparam int unsigned TGT_MSB  = 11;
    localparam int unsigned TGT_LSB  = 8;
    localparam int unsigned DATA_MSB = 7;
    localparam int unsigned DATA_LSB = 0;

    localparam logic [TGT_MSB-TGT_LSB:0] BROADCAST = 4'b1111;

    typedef logic [SRC_MSB-SRC_LSB:0]   port_mask_t;
    typedef logic [DATA_MSB-DATA_LSB:0] pkt_data_t;

    typedef struct packed {
        port_mask_t src;
        port_mask_t tgt;
        pkt_data_t  data;
    } packet_t;

    function automatic port_mask_t port_onehot(input int unsigned port_id);
        return port_mask_t'(1 << port_id);
    endfunction

    function automatic logic is_onehot(input port_mask_t v);
        return (v != '0) && ((v & (v - port_mask_t'(1))) == '0);
    endfunction

    function automatic logic chk_no_src(input packet_t p);
        return p.src == '0;
    endfunction

    function automatic logic chk_multi_src(input packet_t p);
        return (p.src != '0) && !is_onehot(p.src);
    endfunction

    function automatic logic chk_no_tgt(input packet_t p);
        return p.tgt == '0;
    endfunction

    // Broadcast may include the source port; any other target may not.
    function automatic logic chk_self_loop(input packet_t p);
        return (p.tgt != BROADCAST) && ((p.src & p.tgt) != '0);
    endfunction

    function automatic logic chk_src_mismatch(input packet_t p, input port_mask_t own);
        return p.src != own;
    endfunction

    function automatic logic pkt_is_legal(input packet_t p, input port_mask_t own);
        return !(chk_no_src(p) || chk_multi_src(p) || chk_no_tgt(p) ||
                 chk_self_loop(p) || chk_src_mismatch(p, own));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with valid/ready on both sides and an occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    input  logic [WIDTH-1:0]         wr_data_i,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          not_full_q, not_full_d;
    logic          valid_q,    valid_d;

    logic wr_fire;
    logic rd_fire;

    assign wr_fire = wr_valid_i && not_full_q;
    assign rd_fire = rd_ready_i && valid_q;

    // Status flags are precomputed from the next count so they leave as flops.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        not_full_d = not_full_q;
        valid_d    = valid_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        not_full_d = (count_d != CW'(DEPTH));
        valid_d    = (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            not_full_q <= 1'b1;
            valid_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            not_full_q <= not_full_d;
            valid_q    <= valid_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign wr_ready_o = not_full_q;
    assign rd_valid_o = valid_q;
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/port_ingress.sv
// Per-port ingress: screens packets, buffers legal ones, reports drops.
// Optional statistics counters are enabled with PORT_INGRESS_STATS_EN.
module port_ingress #(
    parameter int unsigned PORT_ID    = 0,
    parameter int unsigned FIFO_DEPTH = packet_pkg::FIFO_DEPTH,
    parameter int unsigned PKT_WIDTH  = packet_pkg::PKT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PKT_WIDTH-1:0]          in_pkt,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PKT_WIDTH-1:0]          out_pkt,
    output logic [3:0]                    out_tgt,
    output logic                          drop_pulse,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef PORT_INGRESS_STATS_EN
    ,
    output logic [15:0]                   stat_rx,
    output logic [15:0]                   stat_drop,
    output logic [15:0]                   stat_fwd
`endif
);

    import packet_pkg::*;

    localparam port_mask_t OWN_ONEHOT = port_onehot(PORT_ID);

    packet_t in_hdr;
    logic    accept;
    logic    legal;
    logic    wr_en;
    logic    drop_q, drop_d;

    assign in_hdr = packet_t'(in_pkt);
    assign accept = in_valid && in_ready;
    assign legal  = pkt_is_legal(in_hdr, OWN_ONEHOT);
    assign wr_en  = accept && legal;

    sync_fifo #(
        .WIDTH (PKT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid_i (wr_en),
        .wr_ready_o (in_ready),
        .wr_data_i  (in_pkt),
        .rd_valid_o (out_valid),
        .rd_ready_i (out_ready),
        .rd_data_o  (out_pkt),
        .count_o    (fifo_count)
    );

    assign out_tgt = out_pkt[TGT_MSB:TGT_LSB];

    // Illegal packets are still consumed; the drop is flagged one cycle later.
    always_comb begin
        drop_d = accept && !legal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_pulse = drop_q;

`ifdef PORT_INGRESS_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    logic [15:0] rx_q,   rx_d;
    logic [15:0] drp_q,  drp_d;
    logic [15:0] fwd_q,  fwd_d;

    always_comb begin
        rx_d  = sat_inc(rx_q,  accept);
        drp_d = sat_inc(drp_q, accept && !legal);
        fwd_d = sat_inc(fwd_q, out_valid && out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q  <= '0;
            drp_q <= '0;
            fwd_q <= '0;
        end else begin
            rx_q  <= rx_d;
            drp_q <= drp_d;
            fwd_q <= fwd_d;
        end
    end

    assign stat_rx   = rx_q;
    assign stat_drop = drp_q;
    assign stat_fwd  = fwd_q;
`endif

endmodule
